// File: rtl/hls_deadlock_pkg.sv
// Shared definitions for the HLS SNN deadlock monitors.
//   state_e     : monitor FSM states
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, for index/counter widths
//   AXIS_MASK_* : per-instance stream masks for the monitored sub-instances
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

  // Izhikevich core: only the four outgoing streams can stall it.
  localparam logic [5:0] AXIS_MASK_IZH_DEFAULT = 6'b111100;
  // Input adapter: only the two incoming streams matter.
  localparam logic [5:0] AXIS_MASK_IN_DEFAULT  = 6'b000011;
  // Catch-all for instances touching every stream.
  localparam logic [5:0] AXIS_MASK_ALL         = 6'b111111;

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder.
//   req   : N request bits
//   idx   : index of the lowest set bit of req (0 when none set)
//   valid : at least one bit of req is set
module hls_deadlock_prio_enc
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx = '0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = W'(i - 1);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/hls_snn_izikevich_hls_deadlock_param_monitor.sv
// Parametrised deadlock monitor for one HLS sub-instance.
// Raw block = any child monitor blocked AND any relevant stream blocked AND
// not every instance idle. Raw is filtered through a persistence counter
// (STABLE_CYCLES) and optionally latched (STICKY) before driving block.
//   clock, reset    : rising-edge clock, synchronous active-low reset
//   axis_block_sigs : per-stream blocked flags (filtered by AXIS_MASK)
//   inst_idle_sigs  : per-instance idle flags
//   sub_block_sigs  : block outputs of child monitors
//   clear           : synchronous clear of all detection state
//   block           : registered deadlock indication
//   block_pulse     : one-cycle pulse when block rises
//   block_axis_idx  : lowest masked blocked stream captured at detection
//   block_cycles    : cycles block has been high, saturating
module hls_snn_izikevich_hls_deadlock_param_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned           N_AXIS        = 6,
  parameter int unsigned           N_INST        = 4,
  parameter int unsigned           N_SUB         = 1,
  parameter logic [N_AXIS-1:0]     AXIS_MASK     = N_AXIS'(AXIS_MASK_IZH_DEFAULT),
  parameter int unsigned           STABLE_CYCLES = 1,
  parameter int unsigned           CNT_W         = 16,
  parameter int unsigned           STICKY        = 0,
  localparam int unsigned          IW            = clog2_min1(N_AXIS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_SUB-1:0]  sub_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_pulse,
  output logic [IW-1:0]     block_axis_idx,
  output logic [CNT_W-1:0]  block_cycles
);

  localparam int unsigned    PW       = clog2_min1(STABLE_CYCLES + 1);
  localparam logic [PW-1:0]  STABLE_P = PW'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              block_q, block_d;
  logic              pulse_q, pulse_d;

  logic [IW-1:0]     enc_idx;
  logic              enc_valid;
  logic              raw;

  hls_deadlock_prio_enc #(
    .N (N_AXIS),
    .W (IW)
  ) u_prio_enc (
    .req   (axis_block_sigs & AXIS_MASK),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // enc_valid is exactly |(axis_block_sigs & AXIS_MASK).
  assign raw = (|sub_block_sigs) & enc_valid & ~(&inst_idle_sigs);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      IDLE: begin
        if (raw) begin
          if (STABLE_CYCLES <= 1) begin
            state_d = BLOCKED;
          end else begin
            state_d = SUSPECT;
            cnt_d   = PW'(1);
          end
        end
      end
      SUSPECT: begin
        if (!raw) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q + PW'(1) == STABLE_P) begin
          state_d = BLOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      BLOCKED: begin
        if (!raw && STICKY == 0) begin
          state_d = IDLE;
        end else if (cyc_q != CNT_MAX) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot the offending stream on the cycle block rises.
    if (state_d == BLOCKED && state_q != BLOCKED) begin
      idx_d = enc_idx;
      cyc_d = CNT_W'(1);
    end

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      cyc_d   = '0;
    end

    block_d = (state_d == BLOCKED);
    pulse_d = block_d && (state_q != BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      block_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      block_q <= block_d;
      pulse_q <= pulse_d;
    end
  end

  assign block          = block_q;
  assign block_pulse    = pulse_q;
  assign block_axis_idx = idx_q;
  assign block_cycles   = cyc_q;

endmodule
